// File: rtl/priority_fifo_pkg.sv
// Shared definitions for the priority_fifo ingress path: default payload width,
// priority encoding on the FIFO write port, arbiter states, saturating counter helper.
// Pure declarations, no logic; no latency or backpressure of its own.
package priority_fifo_pkg;

   localparam int DEFAULT_DATA_W = 8;

   // Encoding of priority_in on the FIFO write port
   localparam logic PRIO_LO = 1'b0;
   localparam logic PRIO_HI = 1'b1;

   typedef enum logic {
      HI_PREF  = 1'b0,
      LO_FORCE = 1'b1
   } arb_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ingress_skid2.sv
// 2-entry valid/ready FIFO skid buffer for one producer channel.
// Latency: a word accepted on edge N is visible at out_data from edge N (head) onward.
// Backpressure: in_ready depends only on registered occupancy (low when 2 entries held).
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   in_valid/in_data  producer side; transfer on in_valid & in_ready
//   in_ready          occupancy < 2
//   out_valid         buffer non-empty
//   out_data          head-of-line word
//   pop               consumer removes the head word (ignored when empty)
module ingress_skid2
   import priority_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              pop
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              push;
   logic              do_pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

   assign push   = in_valid & in_ready;
   assign do_pop = pop & out_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         // push and pop together leave occupancy unchanged
         case ({push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/priority_fifo_ingress.sv
// Merges a high- and a low-priority valid/ready stream into the priority_fifo write port.
// Latency: accepted at edge N, loaded to the output register at N+1, write_en during cycle N+1.
// Backpressure: fifo_full holds the output register; skid buffers fill, then x_ready drops.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   hi_valid/hi_data/hi_ready  high-priority producer handshake
//   lo_valid/lo_data/lo_ready  low-priority producer handshake
//   fifo_full                  FIFO full flag
//   fifo_write_en/fifo_data/fifo_priority  FIFO write port (priority 1 = high)
//   hi_grants/lo_grants        saturating counts of words written per priority
module priority_fifo_ingress
   import priority_fifo_pkg::*;
#(
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int HI_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hi_valid,
   input  logic [DATA_W-1:0] hi_data,
   output logic              hi_ready,
   input  logic              lo_valid,
   input  logic [DATA_W-1:0] lo_data,
   output logic              lo_ready,
   input  logic              fifo_full,
   output logic              fifo_write_en,
   output logic [DATA_W-1:0] fifo_data,
   output logic              fifo_priority,
   output logic [15:0]       hi_grants,
   output logic [15:0]       lo_grants
);

   localparam logic [3:0] BURST_LIMIT = 4'(HI_BURST_MAX);

   logic              hi_buf_vld;
   logic [DATA_W-1:0] hi_buf_dat;
   logic              lo_buf_vld;
   logic [DATA_W-1:0] lo_buf_dat;
   logic              pop_hi;
   logic              pop_lo;

   logic              grant_hi;
   logic              load;
   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [3:0]        burst_q;
   logic [3:0]        burst_d;
   logic [3:0]        burst_inc;

   logic              out_vld_q;
   logic [DATA_W-1:0] out_dat_q;
   logic              out_prio_q;
   logic [15:0]       hi_grants_q;
   logic [15:0]       lo_grants_q;

   ingress_skid2 #(.DATA_W(DATA_W)) u_hi_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (hi_valid),
      .in_data   (hi_data),
      .in_ready  (hi_ready),
      .out_valid (hi_buf_vld),
      .out_data  (hi_buf_dat),
      .pop       (pop_hi)
   );

   ingress_skid2 #(.DATA_W(DATA_W)) u_lo_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (lo_valid),
      .in_data   (lo_data),
      .in_ready  (lo_ready),
      .out_valid (lo_buf_vld),
      .out_data  (lo_buf_dat),
      .pop       (pop_lo)
   );

   // Only combinational input-to-output path in the block
   assign fifo_write_en = out_vld_q & ~fifo_full;
   assign fifo_data     = out_dat_q;
   assign fifo_priority = out_prio_q;
   assign hi_grants     = hi_grants_q;
   assign lo_grants     = lo_grants_q;

   // Output register takes a new word when it is empty or being drained this cycle
   assign load   = (~out_vld_q | fifo_write_en) & (hi_buf_vld | lo_buf_vld);
   assign pop_hi = load & grant_hi;
   assign pop_lo = load & ~grant_hi;

   assign burst_inc = burst_q + 4'd1;

   always_comb begin
      grant_hi = 1'b0;
      if (state_q == HI_PREF) begin
         grant_hi = hi_buf_vld;
      end else begin
         grant_hi = ~lo_buf_vld;
      end
   end

   // Burst counter tracks high grants made while a low word sits waiting.
   // The switch to LO_FORCE uses the incremented value so that the low word
   // is served right after exactly HI_BURST_MAX high grants.
   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      if (!lo_buf_vld) begin
         burst_d = '0;
      end
      if (load) begin
         if (state_q == LO_FORCE) begin
            state_d = HI_PREF;
            burst_d = '0;
         end else if (grant_hi) begin
            if (lo_buf_vld) begin
               burst_d = burst_inc;
               if (burst_inc == BURST_LIMIT) begin
                  state_d = LO_FORCE;
               end
            end
         end else begin
            burst_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HI_PREF;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         out_prio_q <= PRIO_LO;
      end else if (load) begin
         out_vld_q  <= 1'b1;
         out_dat_q  <= grant_hi ? hi_buf_dat : lo_buf_dat;
         out_prio_q <= grant_hi ? PRIO_HI : PRIO_LO;
      end else if (fifo_write_en) begin
         out_vld_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_grants_q <= '0;
         lo_grants_q <= '0;
      end else if (fifo_write_en) begin
         if (out_prio_q == PRIO_HI) begin
            hi_grants_q <= sat_inc16(hi_grants_q);
         end else begin
            lo_grants_q <= sat_inc16(lo_grants_q);
         end
      end
   end

endmodule

// File: tb/tb_priority_fifo_ingress.sv
module tb_priority_fifo_ingress;

   localparam int DW  = 8;
   localparam int HBM = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          hi_valid = 1'b0;
   logic [DW-1:0] hi_data = '0;
   logic          hi_ready;
   logic          lo_valid = 1'b0;
   logic [DW-1:0] lo_data = '0;
   logic          lo_ready;
   logic          fifo_full = 1'b0;
   logic          fifo_write_en;
   logic [DW-1:0] fifo_data;
   logic          fifo_priority;
   logic [15:0]   hi_grants;
   logic [15:0]   lo_grants;

   always #5 clk = ~clk;

   priority_fifo_ingress #(.DATA_W(DW), .HI_BURST_MAX(HBM)) dut (
      .clk           (clk),
      .reset         (reset),
      .hi_valid      (hi_valid),
      .hi_data       (hi_data),
      .hi_ready      (hi_ready),
      .lo_valid      (lo_valid),
      .lo_data       (lo_data),
      .lo_ready      (lo_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data     (fifo_data),
      .fifo_priority (fifo_priority),
      .hi_grants     (hi_grants),
      .lo_grants     (lo_grants)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: queues + starvation rule ----------------
   logic [DW-1:0] m_hq[$];
   logic [DW-1:0] m_lq[$];
   logic          m_ov;
   logic [DW-1:0] m_od;
   logic          m_op;
   int            m_streak;   // high writes granted while a low word was waiting
   int            m_hg;
   int            m_lg;

   task automatic model_reset();
      m_hq.delete();
      m_lq.delete();
      m_ov = 1'b0;
      m_od = '0;
      m_op = 1'b0;
      m_streak = 0;
      m_hg = 0;
      m_lg = 0;
   endtask

   task automatic model_step(input logic hv, input logic [DW-1:0] hd, input logic lv,
                             input logic [DW-1:0] ld, input logic full,
                             output logic acc_h, output logic acc_l);
      int   hn;
      int   ln;
      logic we;
      logic load;
      logic take_lo;
      hn = m_hq.size();
      ln = m_lq.size();
      we = m_ov && !full;
      acc_h = hv && (hn < 2);
      acc_l = lv && (ln < 2);
      load = (!m_ov || we) && (hn + ln > 0);
      if (we) begin
         if (m_op) begin
            if (m_hg < 65535) m_hg++;
         end else begin
            if (m_lg < 65535) m_lg++;
         end
      end
      if (load) begin
         // a waiting low word is owed service after HBM high writes
         take_lo = (ln > 0) && ((hn == 0) || (m_streak >= HBM));
         if (take_lo) begin
            m_od = m_lq.pop_front();
            m_op = 1'b0;
            m_streak = 0;
         end else begin
            m_od = m_hq.pop_front();
            m_op = 1'b1;
            if (ln > 0) m_streak++;
         end
         m_ov = 1'b1;
      end else if (we) begin
         m_ov = 1'b0;
      end
      if (ln == 0) m_streak = 0;
      if (acc_h) m_hq.push_back(hd);
      if (acc_l) m_lq.push_back(ld);
   endtask

   // ---------------- source queues, write log, per-cycle driver ----------------
   logic [DW-1:0] hi_src[$];
   logic [DW-1:0] lo_src[$];
   logic [DW-1:0] wr_d[$];
   logic          wr_p[$];
   logic          s_we;
   logic [DW-1:0] s_dat;
   logic          s_hr;
   logic          s_lr;

   // Called just after a rising edge; returns just after the next one.
   task automatic run_cycle(input logic full, input logic h_en, input logic l_en);
      logic acc_h;
      logic acc_l;
      hi_valid  = h_en && (hi_src.size() > 0);
      hi_data   = hi_valid ? hi_src[0] : '0;
      lo_valid  = l_en && (lo_src.size() > 0);
      lo_data   = lo_valid ? lo_src[0] : '0;
      fifo_full = full;
      @(negedge clk);
      chk($sformatf("c%0d hi_ready", cyc), hi_ready, m_hq.size() < 2);
      chk($sformatf("c%0d lo_ready", cyc), lo_ready, m_lq.size() < 2);
      chk($sformatf("c%0d write_en", cyc), fifo_write_en, m_ov && !full);
      chk($sformatf("c%0d data", cyc), fifo_data, m_od);
      chk($sformatf("c%0d prio", cyc), fifo_priority, m_op);
      chk($sformatf("c%0d hi_grants", cyc), hi_grants, m_hg);
      chk($sformatf("c%0d lo_grants", cyc), lo_grants, m_lg);
      s_we = fifo_write_en;
      s_dat = fifo_data;
      s_hr = hi_ready;
      s_lr = lo_ready;
      if (fifo_write_en) begin
         wr_d.push_back(fifo_data);
         wr_p.push_back(fifo_priority);
      end
      model_step(hi_valid, hi_data, lo_valid, lo_data, full, acc_h, acc_l);
      @(posedge clk);
      #1;
      cyc++;
      if (acc_h) void'(hi_src.pop_front());
      if (acc_l) void'(lo_src.pop_front());
   endtask

   task automatic clear_stim();
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      hi_data = '0;
      lo_data = '0;
      fifo_full = 1'b0;
      hi_src.delete();
      lo_src.delete();
      wr_d.delete();
      wr_p.delete();
      model_reset();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      clear_stim();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " hi_ready"}, hi_ready, 1);
      chk({tag, " lo_ready"}, lo_ready, 1);
      chk({tag, " write_en"}, fifo_write_en, 0);
      chk({tag, " data"}, fifo_data, 0);
      chk({tag, " prio"}, fifo_priority, 0);
      chk({tag, " hi_grants"}, hi_grants, 0);
      chk({tag, " lo_grants"}, lo_grants, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic          hv;
      logic [DW-1:0] hd;
      logic          lv;
      logic [DW-1:0] ld;
      logic          full;
      logic          we;
      logic [DW-1:0] d;
      logic          p;
      logic          hr;
      logic          lr;
      logic [15:0]   hg;
      logic [15:0]   lg;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic hv, input logic [7:0] hd, input logic lv,
                               input logic [7:0] ld, input logic we, input logic [7:0] d,
                               input logic p, input logic hr, input logic lr,
                               input logic [15:0] hg, input logic [15:0] lg);
      vec_t v;
      v = '{hv, hd, lv, ld, 1'b0, we, d, p, hr, lr, hg, lg};
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // single low word 0xAA, then preemption: hi BB,DD vs lo AA,CC
      tbl[0]  = mk(0, 8'h00, 1, 8'hAA, 0, 8'h00, 0, 1, 1, 0, 0);
      tbl[1]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0);
      tbl[2]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hAA, 0, 1, 1, 0, 0);
      tbl[3]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 1);
      tbl[4]  = mk(1, 8'hBB, 1, 8'hAA, 0, 8'h00, 0, 1, 1, 0, 1);
      tbl[5]  = mk(1, 8'hDD, 1, 8'hCC, 0, 8'h00, 0, 1, 1, 0, 1);
      tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hBB, 1, 1, 0, 0, 1);
      tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hDD, 1, 1, 0, 1, 1);
      tbl[8]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hAA, 0, 1, 1, 2, 1);
      tbl[9]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hCC, 0, 1, 1, 2, 2);
      tbl[10] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 2, 3);

      // reset state
      clear_stim();
      #1;
      check_reset_outputs("reset0");
      apply_reset();
      check_reset_outputs("after_release");

      // table-driven vectors
      for (int i = 0; i < 11; i++) begin
         hi_valid  = tbl[i].hv;
         hi_data   = tbl[i].hd;
         lo_valid  = tbl[i].lv;
         lo_data   = tbl[i].ld;
         fifo_full = tbl[i].full;
         @(negedge clk);
         chk($sformatf("vec%0d write_en", i), fifo_write_en, tbl[i].we);
         if (tbl[i].we) begin
            chk($sformatf("vec%0d data", i), fifo_data, tbl[i].d);
            chk($sformatf("vec%0d prio", i), fifo_priority, tbl[i].p);
         end
         chk($sformatf("vec%0d hi_ready", i), hi_ready, tbl[i].hr);
         chk($sformatf("vec%0d lo_ready", i), lo_ready, tbl[i].lr);
         chk($sformatf("vec%0d hi_grants", i), hi_grants, tbl[i].hg);
         chk($sformatf("vec%0d lo_grants", i), lo_grants, tbl[i].lg);
         @(posedge clk);
         #1;
      end

      // starvation bound: high always valid, one low word waiting
      apply_reset();
      for (int i = 0; i < 16; i++) hi_src.push_back(8'(8'h10 + i));
      lo_src.push_back(8'h55);
      repeat (10) run_cycle(1'b0, 1'b1, 1'b1);
      chk("starve write count", (wr_d.size() >= 6), 1);
      if (wr_d.size() >= 6) begin
         chk("starve w4 data", wr_d[4], 8'h55);
         chk("starve w4 prio", wr_p[4], 0);
         chk("starve w3 data", wr_d[3], 8'h13);
         chk("starve w5 data", wr_d[5], 8'h14);
         chk("starve w5 prio", wr_p[5], 1);
      end

      // backpressure: full for 6 cycles, both streams offering
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         hi_src.push_back(8'(8'hA0 + i));
         lo_src.push_back(8'(8'hB0 + i));
      end
      for (int c = 0; c < 6; c++) begin
         run_cycle(1'b1, 1'b1, 1'b1);
         chk($sformatf("bp c%0d write_en", c), s_we, 0);
         if (c >= 2) chk($sformatf("bp c%0d held data", c), s_dat, 8'hA0);
         if (c >= 3) begin
            chk($sformatf("bp c%0d hi_ready", c), s_hr, 0);
            chk($sformatf("bp c%0d lo_ready", c), s_lr, 0);
         end
      end
      run_cycle(1'b0, 1'b1, 1'b1);
      chk("bp release write_en", s_we, 1);
      repeat (7) run_cycle(1'b0, 1'b1, 1'b1);
      chk("bp write count", wr_d.size(), 6);
      if (wr_d.size() >= 5) begin
         chk("bp w0", wr_d[0], 8'hA0);
         chk("bp w1", wr_d[1], 8'hA1);
         chk("bp w2", wr_d[2], 8'hA2);
         chk("bp w3", wr_d[3], 8'hB0);
         chk("bp w4", wr_d[4], 8'hB1);
      end

      // asynchronous reset mid-stream with both buffers full
      apply_reset();
      hi_src.push_back(8'h01);
      hi_src.push_back(8'h02);
      repeat (5) run_cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) hi_src.push_back(8'(8'h11 + i));
      for (int i = 0; i < 3; i++) lo_src.push_back(8'(8'h21 + i));
      repeat (5) run_cycle(1'b1, 1'b1, 1'b1);
      chk("pre-reset hi_ready", hi_ready, 0);
      chk("pre-reset hi_grants", hi_grants, 2);
      fifo_full = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      clear_stim();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      hi_src.push_back(8'h71);
      repeat (5) run_cycle(1'b0, 1'b1, 1'b1);
      chk("post-reset write count", wr_d.size(), 1);
      if (wr_d.size() >= 1) chk("post-reset first write", wr_d[0], 8'h71);

      // hi_grants saturation
      apply_reset();
      dut.hi_grants_q = 16'hFFFE;
      m_hg = 16'hFFFE;
      for (int i = 0; i < 3; i++) hi_src.push_back(8'(8'hE1 + i));
      repeat (6) run_cycle(1'b0, 1'b1, 1'b0);
      chk("sat hi_grants", hi_grants, 16'hFFFF);
      chk("sat write count", wr_d.size(), 3);

      // randomized traffic against the model
      apply_reset();
      for (int n = 0; n < 2000; n++) begin
         if (hi_src.size() < 4) hi_src.push_back(8'($urandom));
         if (lo_src.size() < 4) lo_src.push_back(8'($urandom));
         run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_fifo_ingress.md
# priority_fifo_ingress

Upstream feeder for `priority_fifo`. Merges two independent producer streams (high-priority and low-priority) with valid/ready handshakes into the FIFO's single write port. It drives `write_en`, `data_in` and `priority_in`, and honours `full`. A bounded-burst arbiter gives high priority precedence without starving the low-priority stream.

## Interface
Parameters:
- `DATA_W`, 8: payload width; matches the FIFO `data_in`.
- `HI_BURST_MAX`, 4: max consecutive high grants while a low entry is waiting; legal range 1..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset (asserted when 0).
- `hi_valid`, input, 1: high-priority producer has data.
- `hi_data`, input, DATA_W: high-priority payload.
- `hi_ready`, output, 1: high-priority skid buffer can accept.
- `lo_valid`, input, 1: low-priority producer has data.
- `lo_data`, input, DATA_W: low-priority payload.
- `lo_ready`, output, 1: low-priority skid buffer can accept.
- `fifo_full`, input, 1: connects to FIFO `full`.
- `fifo_write_en`, output, 1: connects to FIFO `write_en`.
- `fifo_data`, output, DATA_W: connects to FIFO `data_in`.
- `fifo_priority`, output, 1: connects to FIFO `priority_in` (1 = high).
- `hi_grants`, output, 16: saturating count of high words written.
- `lo_grants`, output, 16: saturating count of low words written.

## Operation
- **Skid buffers.** There is one 2-entry FIFO skid buffer per channel.
  - `x_ready = (occupancy < 2)`, derived from registered state only and never from `x_valid`.
  - A transfer occurs on a rising edge with `x_valid & x_ready`.
- **Output register.** A single entry holding `out_valid`, `fifo_data` and `fifo_priority`.
  - `fifo_write_en = out_valid & ~fifo_full`. This is the only combinational path from an input to an output.
- **Load condition.** The output register loads when `~out_valid | fifo_write_en`, and at least one skid buffer is non-empty.
- **Grant selection.** States are `HI_PREF` and `LO_FORCE`.
  - In `HI_PREF`: grant high if the high skid buffer is non-empty, otherwise grant low.
  - In `LO_FORCE`: grant low if the low skid buffer is non-empty, otherwise grant high.
- **Burst counter** (`burst_cnt`):
  - Increments on each high grant while the low skid buffer is non-empty.
  - Clears on any low grant, or whenever the low skid buffer is empty.
  - In `HI_PREF`, when `burst_cnt == HI_BURST_MAX`, the next state is `LO_FORCE`.
  - In `LO_FORCE`, any grant returns the state to `HI_PREF` and clears `burst_cnt`.
- **Simultaneous events.** Accepting into and popping from the same skid buffer on one edge leaves its occupancy unchanged. The FIFO order of each skid buffer is preserved.
- **Grant counters.** `hi_grants`/`lo_grants` increment on `fifo_write_en` according to `fifo_priority`, and saturate at 0xFFFF.
- **Reset** (`reset == 0`, asynchronous, at any time including mid-transfer):
  - Skid buffers empty; `out_valid = 0`.
  - State `HI_PREF`, `burst_cnt = 0`.
  - Outputs: `hi_ready = lo_ready = 1`, `fifo_write_en = 0`, `fifo_data = 0`, `fifo_priority = 0`, counters = 0.
  - In-flight data is discarded.

## Timing
- **Latency.** Word accepted at edge N → loaded into the output register at edge N+1 (if granted) → `fifo_write_en` high during cycle N+1 if `fifo_full == 0`. The FIFO captures the word at edge N+2.
- **Throughput.** One write per cycle while `fifo_full == 0` and any buffer holds data.
- **Backpressure.** While `fifo_full == 1`:
  - `out_valid` holds, and `fifo_data`/`fifo_priority` stay stable.
  - Skid buffers fill; `x_ready` drops the cycle after occupancy reaches 2.
  - No data loss and no duplication.
- **Release.** When `fifo_full` falls, the write issues in that same cycle.
- **Starvation bound.** A waiting low word is written after at most `HI_BURST_MAX` high writes.

## Structure
- **Shared package `priority_fifo_pkg`:**
  - `DATA_W` default.
  - Priority encoding constants `PRIO_LO = 1'b0`, `PRIO_HI = 1'b1`.
  - Arbiter state enum (`HI_PREF`, `LO_FORCE`).
- **Sub-module `ingress_skid2`:** 2-entry valid/ready skid buffer, parameterised on `DATA_W`, instantiated twice.
- **Top level** holds the arbiter, burst counter, output register and grant counters.

## Test plan
- **Reset.** Drive `reset = 0` mid-stream with both buffers full. Required: all outputs at reset values immediately (asynchronous); after release, the first write is new data only.
- **Single low word.** Low word 0xAA accepted at edge N, `fifo_full = 0`. Required: `fifo_write_en = 1`, `fifo_data = 0xAA`, `fifo_priority = 0` during cycle N+1; `lo_grants = 1`.
- **Preemption.** Low 0xAA, 0xCC and high 0xBB, 0xDD presented on the same edges. Required write order: 0xBB, 0xDD, 0xAA, 0xCC, with priorities 1, 1, 0, 0.
- **Starvation bound.** `HI_BURST_MAX = 4`, high continuously valid, one low word 0x55 waiting. Required: 0x55 is the 5th write; afterwards high resumes.
- **Backpressure.** `fifo_full = 1` for 6 cycles with both streams valid. Required:
  - `fifo_write_en = 0` throughout, with `fifo_data` stable.
  - Both ready signals low once occupancy reaches 2.
  - After `fifo_full` falls, all 5 held words are written in order with no loss.
- **Counter saturation.** Force `hi_grants` to 0xFFFE (preload via a bench hierarchical deposit), then 3 high writes. Required: `hi_grants = 0xFFFF`.
